// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RISC-V immediate generator with valid/ready handshake and optional skid entry
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [TAG_W-1:0] out_tag
);
    typedef enum logic [2:0] {F_NONE, F_I, F_S, F_B, F_U, F_J, F_Z, F_SH} fmt_e;

    logic [6:0]       op;
    logic [2:0]       f3;
    logic             sh;
    logic             rv64;
    logic [31:0]      iv;
    logic [31:0]      v;
    fmt_e             fmt;
    logic [XLEN-1:0]  imm;
    logic             acc;
    logic             sk_valid;
    logic [XLEN-1:0]  sk_imm;
    logic [2:0]       sk_fmt;
    logic [TAG_W-1:0] sk_tag;

    assign op   = in_instr[6:0];
    assign f3   = in_instr[14:12];
    assign sh   = f3[1:0] == 2'b01;
    assign rv64 = XLEN == 64;
    assign iv   = {{20{in_instr[31]}}, in_instr[31:20]};

    // every format is built as a 32-bit value whose bit 31 is the correct sign for XLEN=64
    always_comb begin
        v   = '0;
        fmt = F_NONE;
        case (op)
            7'b0000011, 7'b1100111, 7'b0001111: begin
                fmt = F_I;
                v   = iv;
            end
            7'b0010011: begin
                fmt = sh ? F_SH : F_I;
                v   = sh ? {26'b0, rv64 && in_instr[25], in_instr[24:20]} : iv;
            end
            7'b0011011: begin
                fmt = !rv64 ? F_NONE : sh ? F_SH : F_I;
                v   = !rv64 ? '0 : sh ? {27'b0, in_instr[24:20]} : iv;
            end
            7'b0100011: begin
                fmt = F_S;
                v   = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            7'b1100011: begin
                fmt = F_B;
                v   = {{20{in_instr[31]}}, in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                fmt = F_U;
                v   = {in_instr[31:12], 12'b0};
            end
            7'b1101111: begin
                fmt = F_J;
                v   = {{12{in_instr[31]}}, in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
            end
            7'b1110011: begin
                fmt = f3[2] ? F_Z : F_NONE;
                v   = f3[2] ? {27'b0, in_instr[19:15]} : '0;
            end
            default: ;
        endcase
        imm = XLEN'($signed(v));
    end

    assign in_ready = SKID != 0 ? !sk_valid : (!out_valid || out_ready);
    assign acc      = in_valid && in_ready;

    // the skid entry is always older than any new accept, so it drains to the output first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_imm   <= '0;
            out_fmt   <= '0;
            out_tag   <= '0;
            sk_valid  <= 1'b0;
            sk_imm    <= '0;
            sk_fmt    <= '0;
            sk_tag    <= '0;
        end else begin
            if (sk_valid && out_ready) begin
                out_imm  <= sk_imm;
                out_fmt  <= sk_fmt;
                out_tag  <= sk_tag;
                sk_valid <= 1'b0;
            end else if (acc && (!out_valid || out_ready)) begin
                out_valid <= 1'b1;
                out_imm   <= imm;
                out_fmt   <= fmt;
                out_tag   <= in_tag;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (SKID != 0 && acc && out_valid && !out_ready) begin
                sk_valid <= 1'b1;
                sk_imm   <= imm;
                sk_fmt   <= fmt;
                sk_tag   <= in_tag;
            end
        end
    end
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: vector table, backpressure/reset sequences and random streams on XLEN=32/SKID=1 and XLEN=64/SKID=0
module tb_imm_gen_pipe;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        iv32, ir32, ov32, or32;
    logic [31:0] ii32, oimm32;
    logic [7:0]  it32, ot32;
    logic [2:0]  of32;
    logic        iv64, ir64, ov64, or64;
    logic [31:0] ii64;
    logic [63:0] oimm64;
    logic [7:0]  it64, ot64;
    logic [2:0]  of64;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(8), .SKID(1)) u32 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv32), .in_ready(ir32), .in_instr(ii32), .in_tag(it32),
        .out_valid(ov32), .out_ready(or32), .out_imm(oimm32), .out_fmt(of32), .out_tag(ot32));

    imm_gen_pipe #(.XLEN(64), .TAG_W(8), .SKID(0)) u64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64), .in_instr(ii64), .in_tag(it64),
        .out_valid(ov64), .out_ready(or64), .out_imm(oimm64), .out_fmt(of64), .out_tag(ot64));

    typedef struct {
        logic [31:0] instr;
        bit          x64;
        logic [63:0] imm;
        logic [2:0]  fmt;
    } vec_t;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // reference decode from the field layout, using signed arithmetic on the assembled value
    function automatic logic [66:0] model(logic [31:0] i, bit x64);
        longint      v = 0;
        int          f = 0;
        logic [6:0]  op = i[6:0];
        logic [2:0]  f3 = i[14:12];
        bit          sh = (f3 == 3'd1 || f3 == 3'd5);
        if (op == 7'h03 || op == 7'h67 || op == 7'h0F || (op == 7'h13 && !sh) || (op == 7'h1B && x64 && !sh)) begin
            f = 1; v = i[31:20];
            if (v >= 2048) v -= 4096;
        end else if (op == 7'h13 && sh) begin
            f = 7; v = x64 ? i[25:20] : i[24:20];
        end else if (op == 7'h1B && x64 && sh) begin
            f = 7; v = i[24:20];
        end else if (op == 7'h23) begin
            f = 2; v = i[31:25] * 32 + i[11:7];
            if (v >= 2048) v -= 4096;
        end else if (op == 7'h63) begin
            f = 3; v = i[31] * 4096 + i[7] * 2048 + i[30:25] * 32 + i[11:8] * 2;
            if (v >= 4096) v -= 8192;
        end else if (op == 7'h37 || op == 7'h17) begin
            f = 4; v = i[31:12] * 4096;
            if (v >= 64'h8000_0000) v -= 64'h1_0000_0000;
        end else if (op == 7'h6F) begin
            f = 5; v = i[31] * 1048576 + i[19:12] * 4096 + i[20] * 2048 + i[30:21] * 2;
            if (v >= 1048576) v -= 2097152;
        end else if (op == 7'h73 && f3[2]) begin
            f = 6; v = i[19:15];
        end
        return {3'(f), x64 ? 64'(v) : {32'b0, 32'(v)}};
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [6:0]  ops [12] = '{7'h03, 7'h67, 7'h0F, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};
        logic [31:0] r = $urandom;
        if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 11)];
        return r;
    endfunction

    task automatic apply(bit x64, logic [31:0] ins, logic [7:0] tg, logic [63:0] ei, logic [2:0] ef);
        if (x64) begin iv64 = 1; ii64 = ins; it64 = tg; end
        else begin iv32 = 1; ii32 = ins; it32 = tg; end
        #1 check("vec_rdy", x64 ? ir64 : ir32, 1);
        @(posedge clk); #1;
        iv32 = 0; iv64 = 0;
        check("vec_valid", x64 ? ov64 : ov32, 1);
        check("vec_imm", x64 ? oimm64 : {32'b0, oimm32}, ei);
        check("vec_fmt", x64 ? of64 : of32, ef);
        check("vec_tag", x64 ? ot64 : ot32, tg);
    endtask

    task automatic run_rand(bit x64, int n);
        logic [31:0] qi[$];
        logic [7:0]  qt[$];
        logic [66:0] m;
        logic [31:0] cur = 0;
        logic [7:0]  curtag = 0;
        logic [63:0] oimm;
        bit pend = 0;
        bit ov, ir, orr;
        int sent = 0;
        int cyc = 0;
        while ((sent < n || qi.size() > 0) && cyc < 5000) begin
            if (!pend && sent < n && $urandom_range(0, 3) != 0) begin
                cur = rnd_instr(); curtag = 8'(sent + 1); pend = 1;
            end
            orr = 1'($urandom_range(0, 1));
            if (x64) begin iv64 = pend; ii64 = cur; it64 = curtag; or64 = orr; end
            else begin iv32 = pend; ii32 = cur; it32 = curtag; or32 = orr; end
            #1;
            ov = x64 ? ov64 : ov32;
            ir = x64 ? ir64 : ir32;
            oimm = x64 ? oimm64 : {32'b0, oimm32};
            check("rand_rdy", ir, x64 ? (qi.size() == 0 || orr) : (qi.size() < 2));
            check("rand_valid", ov, qi.size() > 0);
            if (ov && orr && qi.size() > 0) begin
                m = model(qi[0], x64);
                check("rand_imm", oimm, m[63:0]);
                check("rand_fmt", x64 ? of64 : of32, m[66:64]);
                check("rand_tag", x64 ? ot64 : ot32, qt[0]);
                void'(qi.pop_front());
                void'(qt.pop_front());
            end
            if (pend && ir) begin
                qi.push_back(cur); qt.push_back(curtag); sent++; pend = 0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("rand_done", {sent == n, qi.size() == 0}, 2'b11);
        iv32 = 0; iv64 = 0; or32 = 1; or64 = 1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[$];
        rst_n = 0;
        iv32 = 0; ii32 = 0; it32 = 0; or32 = 1;
        iv64 = 0; ii64 = 0; it64 = 0; or64 = 1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid32", ov32, 0);
        check("rst_imm32", oimm32, 0);
        check("rst_fmt32", of32, 0);
        check("rst_tag32", ot32, 0);
        check("rst_valid64", ov64, 0);
        check("rst_imm64", oimm64, 0);
        rst_n = 1;
        @(posedge clk); #1;
        check("rel_rdy32", ir32, 1);
        check("rel_rdy64", ir64, 1);

        vt.push_back('{32'hFFF00093, 0, 64'h0000_0000_FFFF_FFFF, 3'd1});
        vt.push_back('{32'hFE000EE3, 0, 64'h0000_0000_FFFF_FFFC, 3'd3});
        vt.push_back('{32'h0010006F, 0, 64'h0000_0000_0000_0800, 3'd5});
        vt.push_back('{32'h4030D093, 0, 64'h0000_0000_0000_0003, 3'd7});
        vt.push_back('{32'h3002D073, 0, 64'h0000_0000_0000_0005, 3'd6});
        vt.push_back('{32'hFE112C23, 0, 64'h0000_0000_FFFF_FFF8, 3'd2});
        vt.push_back('{32'h0000101B, 0, 64'h0, 3'd0});
        vt.push_back('{32'h00000033, 0, 64'h0, 3'd0});
        vt.push_back('{32'h30029073, 0, 64'h0, 3'd0});
        vt.push_back('{32'h4200D093, 0, 64'h0, 3'd7});
        vt.push_back('{32'h0FF0000F, 0, 64'h0000_0000_0000_00FF, 3'd1});
        vt.push_back('{32'h80000037, 1, 64'hFFFF_FFFF_8000_0000, 3'd4});
        vt.push_back('{32'h0000101B, 1, 64'h0, 3'd7});
        vt.push_back('{32'h4200D093, 1, 64'h0000_0000_0000_0020, 3'd7});
        vt.push_back('{32'hFFF0001B, 1, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1});
        vt.push_back('{32'hFE000EE3, 1, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3});
        vt.push_back('{32'h80000017, 0, 64'h0000_0000_8000_0000, 3'd4});
        for (int k = 0; k < vt.size(); k++)
            apply(vt[k].x64, vt[k].instr, 8'(8'h30 + k), vt[k].imm, vt[k].fmt);
        @(posedge clk); #1;

        // single-entry backpressure: in_ready drops and output holds until consumed
        or64 = 0; iv64 = 1; ii64 = 32'hFFF00093; it64 = 8'h55;
        @(posedge clk); #1;
        ii64 = 32'h00000037; it64 = 8'h66;
        #1 check("bp_rdy_low", ir64, 0);
        @(posedge clk); #1;
        check("bp_hold_tag", ot64, 8'h55);
        check("bp_hold_imm", oimm64, 64'hFFFF_FFFF_FFFF_FFFF);
        check("bp_hold_valid", ov64, 1);
        or64 = 1;
        #1 check("bp_rdy_high", ir64, 1);
        @(posedge clk); #1;
        iv64 = 0;
        check("bp_next_tag", ot64, 8'h66);
        check("bp_next_imm", oimm64, 64'h0);
        check("bp_next_fmt", of64, 3'd4);
        @(posedge clk); #1;
        check("bp_empty", ov64, 0);

        run_rand(0, 200);
        run_rand(1, 200);

        // two entries held in the skid configuration, then reset mid-flight
        or32 = 0; iv32 = 1; ii32 = 32'hFFF00093; it32 = 8'hA1;
        @(posedge clk); #1;
        ii32 = 32'h0010006F; it32 = 8'hA2;
        @(posedge clk); #1;
        iv32 = 0;
        check("full_rdy", ir32, 0);
        check("full_tag", ot32, 8'hA1);
        rst_n = 0;
        #1;
        check("mid_rst_valid", ov32, 0);
        check("mid_rst_tag", ot32, 0);
        check("mid_rst_rdy", ir32, 1);
        @(posedge clk); #1;
        rst_n = 1; or32 = 1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check("post_rst_empty", ov32, 0);
        end
        apply(0, 32'h3002D073, 8'hB0, 64'h5, 3'd6);
        @(posedge clk); #1;
        check("post_rst_drain", ov32, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
